// File: rtl/divider_64bit_seq_if.sv
// Operand/result bundle for the sequential divider.
// master drives the request, slave (the divider) returns the results.
interface divider_64bit_seq_if #(
    parameter int unsigned WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_64bit_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// trial subtraction done by the shared subtractor.
module subtractor #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] difference,
    output logic             overflow
);
    assign difference = a - b - {{(WIDTH-1){1'b0}}, c_in};
    // Signed overflow: operands differ in sign and result sign differs from a.
    assign overflow = (a[WIDTH-1] != b[WIDTH-1]) && (difference[WIDTH-1] != a[WIDTH-1]);
endmodule

module divider_64bit_seq #(
    parameter int unsigned WIDTH = 64
) (
    input logic                 clk,
    input logic                 reset,
    divider_64bit_seq_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   cmp;
    logic             accept;
    logic [WIDTH-1:0] sub_diff;
    logic             unused_sub_overflow;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    assign sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

    subtractor #(.WIDTH(WIDTH)) u_sub (
        .a          (sh[WIDTH-1:0]),
        .b          (dvs_q),
        .c_in       (1'b0),
        .difference (sub_diff),
        .overflow   (unused_sub_overflow)
    );

    // Local borrow; a set sh MSB means the partial remainder already exceeds dvs.
    assign cmp      = {1'b0, sh[WIDTH-1:0]} - {1'b0, dvs_q};
    assign accept   = sh[WIDTH] | ~cmp[WIDTH];
    assign rem_next = accept ? {1'b0, sub_diff} : sh;
    assign quo_next = {quo_q[WIDTH-2:0], accept};

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                        state_d     = StDone;
                    end else begin
                        rem_d   = '0;
                        quo_d   = bus.dividend;
                        dvs_d   = bus.divisor;
                        count_d = '0;
                        dbz_d   = 1'b0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                rem_d   = rem_next;
                quo_d   = quo_next;
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    quotient_d  = quo_next;
                    remainder_d = rem_next[WIDTH-1:0];
                    state_d     = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = (state_q == StDone);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider_64bit_seq.sv
// Directed-vector bench for divider_64bit_seq; every expectation is hand-computed.
module tb_divider_64bit_seq;
    logic clk;
    logic reset;

    divider_64bit_seq_if #(.WIDTH(64)) bus ();

    divider_64bit_seq #(.WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks;
    int n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the done cycle.
    task automatic run_div(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] eq, input logic [63:0] er, input logic edbz,
                           input int elat, input int inject_at);
        int lat;
        int busy_cnt;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat       = 1;
        busy_cnt  = 0;
        forever begin
            if (lat == inject_at) begin
                bus.start    = 1'b1;
                bus.dividend = 64'd50;
                bus.divisor  = 64'd5;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done || lat >= 200) break;
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(elat));
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(elat));
        check({tag, " quotient"}, bus.quotient, eq);
        check({tag, " remainder"}, bus.remainder, er);
        check({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(edbz));
        @(negedge clk);
        check({tag, " done one cycle"}, 64'(bus.done), 64'd0);
        check({tag, " busy falls"}, 64'(bus.busy), 64'd0);
        check({tag, " quotient held"}, bus.quotient, eq);
    endtask

    initial begin
        bit done_seen;
        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset quotient", bus.quotient, 64'd0);
        check("reset remainder", bus.remainder, 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset dbz", 64'(bus.div_by_zero), 64'd0);

        run_div("100/7", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65, 0);
        run_div("max/1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 65, 0);
        run_div("max/msb", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
                64'd1, 64'h7FFF_FFFF_FFFF_FFFE, 1'b0, 65, 0);
        run_div("small/big", 64'd738468, 64'd900000, 64'd0, 64'd738468, 1'b0, 65, 0);
        run_div("7446525/1e6", 64'd7446525, 64'd1000000, 64'd7, 64'd446525, 1'b0, 65, 0);
        run_div("div0", 64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd12345, 1'b1, 1, 0);
        run_div("dbz clear", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65, 0);
        run_div("ignored start", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65, 20);
        run_div("back-to-back", 64'd50, 64'd5, 64'd10, 64'd0, 1'b0, 65, 0);

        // Abort an operation mid-RUN with reset.
        bus.start    = 1'b1;
        bus.dividend = 64'd100;
        bus.divisor  = 64'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (29) @(negedge clk);
        check("mid-run busy", 64'(bus.busy), 64'd1);
        check("mid-run quotient stable", bus.quotient, 64'd10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort quotient", bus.quotient, 64'd0);
        check("abort remainder", bus.remainder, 64'd0);
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort done", 64'(bus.done), 64'd0);
        done_seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (bus.done) done_seen = 1'b1;
        end
        check("abort no done", 64'(done_seen), 64'd0);
        run_div("9/3", 64'd9, 64'd3, 64'd3, 64'd0, 1'b0, 65, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
